dmem_stage: RTL and testbench
=============================

# dmem_stage

Parametrised successor to the pipeline's memory-access stage. It serves loads and stores from the EX/MEM register against an internal word-organised data memory, with:
- byte, halfword and word access sizes;
- sign/zero load extension and misalignment detection;
- a programmable wait-state counter that stalls the pipeline for slow memory.

Its registered load result feeds the MEM/WB register.

## Interface
Parameters:
- ADDR_W, 10, word-address bits; memory depth is 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 0, extra cycles per access (0..15); 0 gives single-cycle access with no stall.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  access requested this cycle.
- mem_write  in  1  1 = store, 0 = load.
- mem_op  in  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101..111 reserved. Stores ignore signedness.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data, right-aligned.
- rdata  out  32  extended load result, registered.
- rdata_valid  out  1  one-cycle pulse, load result valid.
- stall  out  1  combinational; upstream must hold its request while high.
- misalign  out  1  one-cycle pulse, misaligned request was dropped.

## Operation
- Memory layout:
  - word index = addr[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap.
  - lane k = bits 8k+7:8k (little-endian).
- Alignment:
  - word requires addr[1:0]=00.
  - half requires addr[0]=0.
  - byte is always aligned.
- Misaligned request: no write, no rdata_valid, no stall; misalign pulses in the next cycle.
- Reserved mem_op: dropped silently; no misalign pulse.
- Store:
  - byte writes wdata[7:0] to lane addr[1:0].
  - half writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - word writes all lanes.
  - other lanes are untouched.
- Load:
  - selects the lane(s), then sign- or zero-extends per mem_op.
  - result is registered into rdata with rdata_valid=1.
  - rdata holds its value until the next load completes.
- FSM states: IDLE, BUSY. A 4-bit counter cnt runs alongside.
  - IDLE, accepted request, WAIT_CYCLES=0: access performed at this edge; stay IDLE.
  - IDLE, accepted request, WAIT_CYCLES>0: capture mem_write, mem_op, addr, wdata; cnt<=WAIT_CYCLES; go to BUSY.
  - BUSY: req_valid is ignored. cnt decrements every edge. At the edge where cnt==1, the captured access is performed and the FSM returns to IDLE.
- stall = reset & ((IDLE & req_valid & aligned & legal op & WAIT_CYCLES>0) | (BUSY & cnt!=1)).
- Reset, asynchronous and applied at any time:
  - state=IDLE, cnt=0.
  - rdata=0, rdata_valid=0, misalign=0; stall forced 0.
  - any pending BUSY access is abandoned and performs no write.
  - memory contents are not cleared.

## Timing
- WAIT_CYCLES=0:
  - request in cycle t; a store updates memory at the end of t.
  - for a load, rdata/rdata_valid are visible in t+1.
- WAIT_CYCLES=W>0:
  - stall is high in cycles t..t+W-1 and low in t+W.
  - the access is performed at the end of t+W; load data is visible in t+W+1.
- Back-to-back requests: the next request may be presented in the cycle after completion (t+1 when W=0, t+W+1 when W>0) with no bubble.
- Read-after-write to the same word in consecutive requests returns the newly written data.
- misalign is visible in t+1 regardless of W.

## Test plan
- Reset with W=0: after reset deasserts, all outputs are 0. Store word 0xDEADBEEF @0x10, then load word @0x10 → rdata=0xDEADBEEF, rdata_valid pulses for exactly one cycle, stall never rises.
- Byte and half lanes: store byte 0x80 @0x21, then load byte signed @0x21 → 0xFFFFFF80; load byte unsigned → 0x00000080; load word @0x20 shows 0x80 only in lane 1. Store half 0x8001 @0x22, then load half signed → 0xFFFF8001.
- Misalignment: load word @0x13 and store half @0x15 → misalign pulses in t+1, rdata_valid stays 0, memory is unchanged (verify with a later aligned load).
- Wait states, W=3: a single load has stall high for exactly 3 cycles and rdata_valid in t+4. Two back-to-back stores followed by a load each take 4 cycles with no lost or duplicated writes.
- Reset mid-access, W=3: assert reset during the second BUSY cycle of a store to 0x40 → no write occurs (later load @0x40 returns the old value), stall drops immediately, state returns to IDLE.
- Wrap and reserved op: with ADDR_W=10, store @0x1000 aliases to word 0. A request with mem_op=101 produces no write, no rdata_valid, no misalign.

Source files
------------

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response bundle between the pipeline and dmem_stage
`timescale 1ns/1ps

interface dmem_if;
  logic        req_valid;
  logic        mem_write;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        stall;
  logic        misalign;

  modport master (
    output req_valid, mem_write, mem_op, addr, wdata,
    input  rdata, rdata_valid, stall, misalign
  );

  modport slave (
    input  req_valid, mem_write, mem_op, addr, wdata,
    output rdata, rdata_valid, stall, misalign
  );
endinterface

// File: rtl/dmem_stage.sv
// rtl/dmem_stage.sv - memory-access stage with internal word memory, extension and wait states
`timescale 1ns/1ps

module dmem_stage #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_HS = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_BS = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);
  localparam int         DEPTH    = 2 ** ADDR_W;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic        capture;
  logic        stall_int;

  // Request decode results for the live request presented on the bus.
  logic        req_legal;
  logic        req_aligned;
  logic        req_accept;
  logic        req_misalign;

  // Captured request for multi-cycle accesses.
  logic              cap_write;
  logic [2:0]        cap_op;
  logic [ADDR_W+1:0] cap_addr;
  logic [31:0]       cap_wdata;

  // The access actually performed at the coming edge.
  logic              acc_en;
  logic              acc_write;
  logic [2:0]        acc_op;
  logic [ADDR_W+1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-1:0] acc_idx;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] ld_data;
  logic [31:0] wr_lanes;
  logic [3:0]  wr_be;

  logic [31:0] rdata_q;
  logic        rdata_valid_q;
  logic        misalign_q;

  // Address bits above the memory window are ignored so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  // Classify the live request: legal opcode, natural alignment, accept or misalign.
  always_comb begin
    req_legal   = 1'b0;
    req_aligned = 1'b0;
    case (bus.mem_op)
      OP_W: begin
        req_legal   = 1'b1;
        req_aligned = (bus.addr[1:0] == 2'b00);
      end
      OP_HS, OP_HU: begin
        req_legal   = 1'b1;
        req_aligned = (bus.addr[0] == 1'b0);
      end
      OP_BS, OP_BU: begin
        req_legal   = 1'b1;
        req_aligned = 1'b1;
      end
      default: begin
        req_legal   = 1'b0;
        req_aligned = 1'b0;
      end
    endcase
    req_accept   = (state == IDLE) && bus.req_valid && req_legal && req_aligned;
    req_misalign = (state == IDLE) && bus.req_valid && req_legal && !req_aligned;
  end

  // Next-state logic: IDLE accepts, BUSY counts down the wait states to completion.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    stall_int  = 1'b0;
    case (state)
      IDLE: begin
        if (req_accept && HAS_WAIT) begin
          state_next = BUSY;
          cnt_next   = CNT_INIT;
          capture    = 1'b1;
          stall_int  = 1'b1;
        end
      end
      BUSY: begin
        cnt_next  = cnt - 4'd1;
        stall_int = (cnt != 4'd1);
        if (cnt == 4'd1) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
    if (!reset) begin
      stall_int = 1'b0;
    end
  end

  // State and wait counter; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Hold the accepted request while the wait states elapse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_write <= 1'b0;
      cap_op    <= 3'b000;
      cap_addr  <= '0;
      cap_wdata <= 32'd0;
    end else if (capture) begin
      cap_write <= bus.mem_write;
      cap_op    <= bus.mem_op;
      cap_addr  <= bus.addr[ADDR_W+1:0];
      cap_wdata <= bus.wdata;
    end
  end

  // Pick the live request for single-cycle operation, the captured one otherwise.
  always_comb begin
    acc_en    = 1'b0;
    acc_write = 1'b0;
    acc_op    = OP_W;
    acc_addr  = '0;
    acc_wdata = 32'd0;
    if (HAS_WAIT) begin
      acc_en    = (state == BUSY) && (cnt == 4'd1) && reset;
      acc_write = cap_write;
      acc_op    = cap_op;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
    end else begin
      acc_en    = req_accept && reset;
      acc_write = bus.mem_write;
      acc_op    = bus.mem_op;
      acc_addr  = bus.addr[ADDR_W+1:0];
      acc_wdata = bus.wdata;
    end
    acc_idx = acc_addr[ADDR_W+1:2];
  end

  // Replicate store data across lanes and enable only the addressed lanes.
  always_comb begin
    wr_lanes = acc_wdata;
    wr_be    = 4'b1111;
    case (acc_op)
      OP_HS, OP_HU: begin
        wr_lanes = {2{acc_wdata[15:0]}};
        wr_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_BS, OP_BU: begin
        wr_lanes = {4{acc_wdata[7:0]}};
        wr_be    = 4'b0001 << acc_addr[1:0];
      end
      default: begin
        wr_lanes = acc_wdata;
        wr_be    = 4'b1111;
      end
    endcase
  end

  // Lane-masked memory write; contents are kept across reset.
  always_ff @(posedge clk) begin
    if (acc_en && acc_write) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) begin
          mem[acc_idx][8*k +: 8] <= wr_lanes[8*k +: 8];
        end
      end
    end
  end

  // Bring the addressed lane(s) down to bit 0 and extend per opcode.
  always_comb begin
    rd_word  = mem[acc_idx];
    rd_shift = rd_word >> {acc_addr[1:0], 3'b000};
    case (acc_op)
      OP_HS:   ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      OP_HU:   ld_data = {16'd0, rd_shift[15:0]};
      OP_BS:   ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      OP_BU:   ld_data = {24'd0, rd_shift[7:0]};
      default: ld_data = rd_word;
    endcase
  end

  // Registered load result and one-cycle status pulses toward MEM/WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      rdata_valid_q <= acc_en && !acc_write;
      misalign_q    <= req_misalign;
      if (acc_en && !acc_write) begin
        rdata_q <= ld_data;
      end
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.misalign    = misalign_q;
  assign bus.stall       = stall_int;

endmodule

// File: tb/tb_dmem_stage.sv
// tb/tb_dmem_stage.sv - scoreboard bench for dmem_stage with W=0 and W=3 instances
`timescale 1ns/1ps

module tb_dmem_stage;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_HS = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_BS = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  dmem_if bus0 ();
  dmem_if bus1 ();

  dmem_stage #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset(rst0), .bus(bus0.slave));
  dmem_stage #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut1 (.clk(clk), .reset(rst1), .bus(bus1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: byte-addressed 4 KiB image per DUT, plus expected-response queues.
  logic [7:0]  bmem [2][4096];
  int          rd_cyc [2][$];
  logic [31:0] rd_dat [2][$];
  int          mis_cyc [2][$];
  logic [31:0] hold [2];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  function automatic int op_size(input logic [2:0] op);
    case (op)
      OP_W:         return 4;
      OP_HS, OP_HU: return 2;
      OP_BS, OP_BU: return 1;
      default:      return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input int d, input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v;
    int base;
    v = 32'd0;
    base = int'(a[11:0]);
    for (int i = 0; i < op_size(op); i++) v = v | (32'(bmem[d][(base + i) % 4096]) << (8 * i));
    if (op == OP_HS) v = {{16{v[15]}}, v[15:0]};
    if (op == OP_BS) v = {{24{v[7]}}, v[7:0]};
    return v;
  endfunction

  task automatic model_store(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int base;
    base = int'(a[11:0]);
    for (int i = 0; i < op_size(op); i++) bmem[d][(base + i) % 4096] = wd[8*i +: 8];
  endtask

  task automatic drive(input int d, input logic v, input logic wr, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      bus0.req_valid = v; bus0.mem_write = wr; bus0.mem_op = op; bus0.addr = a; bus0.wdata = wd;
    end else begin
      bus1.req_valid = v; bus1.mem_write = wr; bus1.mem_op = op; bus1.addr = a; bus1.wdata = wd;
    end
  endtask

  function automatic logic get_stall(input int d);
    return (d == 0) ? bus0.stall : bus1.stall;
  endfunction

  // One request: drive at negedge, hold while stalled, drop after the completing edge.
  task automatic access(input int d, input logic wr, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input bit use_exp, input logic [31:0] exp_v);
    int t, stalls, n, w;
    bit legal, aligned;
    n = op_size(op);
    legal = (n != 0);
    aligned = legal && ((int'(a[11:0]) % (legal ? n : 1)) == 0);
    w = (d == 0) ? 0 : 3;
    @(negedge clk);
    t = cyc;
    drive(d, 1'b1, wr, op, a, wd);
    if (legal && aligned) begin
      if (wr) model_store(d, op, a, wd);
      else begin
        rd_cyc[d].push_back(t + w + 1);
        rd_dat[d].push_back(use_exp ? exp_v : model_load(d, op, a));
      end
    end else if (legal) begin
      mis_cyc[d].push_back(t + 1);
    end
    stalls = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (!get_stall(d)) break;
      stalls++;
      @(negedge clk);
    end
    chk("stall_cycles", d, stalls, (legal && aligned) ? w : 0);
    @(posedge clk);
    #1 drive(d, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a pulse.
  task automatic monitor_dut(input int d);
    logic r, v, m;
    logic [31:0] rd;
    int ec;
    logic [31:0] ed;
    r  = (d == 0) ? rst0 : rst1;
    v  = (d == 0) ? bus0.rdata_valid : bus1.rdata_valid;
    m  = (d == 0) ? bus0.misalign : bus1.misalign;
    rd = (d == 0) ? bus0.rdata : bus1.rdata;
    if (!r) hold[d] = 32'd0;
    if (v) begin
      if (rd_cyc[d].size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rdata_valid dut%0d got 1 expected 0 (cycle %0d)", d, cyc);
      end else begin
        ec = rd_cyc[d].pop_front();
        ed = rd_dat[d].pop_front();
        chk("rdata_valid_cycle", d, cyc, ec);
        chk("rdata", d, rd, ed);
        hold[d] = ed;
      end
    end else begin
      chk("rdata_hold", d, rd, hold[d]);
    end
    if (m) begin
      if (mis_cyc[d].size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_misalign dut%0d got 1 expected 0 (cycle %0d)", d, cyc);
      end else begin
        ec = mis_cyc[d].pop_front();
        chk("misalign_cycle", d, cyc, ec);
      end
    end
    if (d == 0) chk("stall_w0", d, 32'(bus0.stall), 32'd0);
  endtask

  always @(negedge clk) begin
    monitor_dut(0);
    monitor_dut(1);
  end

  task automatic directed(input int d);
    access(d, 1, OP_W,  32'h10,   32'hDEADBEEF, 0, 0);
    access(d, 0, OP_W,  32'h10,   0, 1, 32'hDEADBEEF);
    access(d, 1, OP_W,  32'h20,   32'h0, 0, 0);
    access(d, 1, OP_BS, 32'h21,   32'hAAAA5580, 0, 0);
    access(d, 0, OP_BS, 32'h21,   0, 1, 32'hFFFFFF80);
    access(d, 0, OP_BU, 32'h21,   0, 1, 32'h00000080);
    access(d, 0, OP_W,  32'h20,   0, 1, 32'h00008000);
    access(d, 1, OP_HS, 32'h22,   32'h12348001, 0, 0);
    access(d, 0, OP_HS, 32'h22,   0, 1, 32'hFFFF8001);
    access(d, 0, OP_HU, 32'h22,   0, 1, 32'h00008001);
    access(d, 0, OP_W,  32'h20,   0, 1, 32'h80018000);
    access(d, 0, OP_W,  32'h13,   0, 0, 0);
    access(d, 1, OP_HS, 32'h15,   32'h0000FFFF, 0, 0);
    access(d, 0, OP_W,  32'h10,   0, 1, 32'hDEADBEEF);
    access(d, 0, OP_W,  32'h14,   0, 0, 0);
    access(d, 1, OP_W,  32'h1000, 32'hCAFEF00D, 0, 0);
    access(d, 0, OP_W,  32'h0,    0, 1, 32'hCAFEF00D);
    access(d, 1, 3'b101, 32'h0,   32'h11111111, 0, 0);
    access(d, 0, 3'b110, 32'h0,   0, 0, 0);
    access(d, 0, OP_W,  32'h0,    0, 1, 32'hCAFEF00D);
  endtask

  // Store to 0x40 on the W=3 instance, reset in its second busy cycle.
  task automatic reset_mid_access();
    @(negedge clk);
    drive(1, 1'b1, 1'b1, OP_W, 32'h40, 32'h5A5A5A5A);
    #1 chk("stall_at_issue", 1, 32'(bus1.stall), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst1 = 1'b0;
    #1;
    chk("stall_in_reset", 1, 32'(bus1.stall), 32'd0);
    chk("rdata_in_reset", 1, bus1.rdata, 32'd0);
    chk("valid_in_reset", 1, 32'(bus1.rdata_valid), 32'd0);
    chk("misalign_in_reset", 1, 32'(bus1.misalign), 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(posedge clk);
    #2 rst1 = 1'b1;
    repeat (6) @(negedge clk);
    chk("stall_after_reset", 1, 32'(bus1.stall), 32'd0);
    access(1, 0, OP_W, 32'h40, 0, 0, 0);
  endtask

  initial begin
    logic [2:0] op;
    logic [31:0] a;
    rst0 = 1'b1;
    rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    #1 rst0 = 1'b0; rst1 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst0 = 1'b1; rst1 = 1'b1;
    @(negedge clk);
    chk("reset_rdata", 0, bus0.rdata, 32'd0);
    chk("reset_valid", 0, 32'(bus0.rdata_valid), 32'd0);
    chk("reset_stall", 0, 32'(bus0.stall), 32'd0);
    chk("reset_misalign", 0, 32'(bus0.misalign), 32'd0);
    chk("reset_rdata", 1, bus1.rdata, 32'd0);
    chk("reset_valid", 1, 32'(bus1.rdata_valid), 32'd0);
    chk("reset_stall", 1, 32'(bus1.stall), 32'd0);
    chk("reset_misalign", 1, 32'(bus1.misalign), 32'd0);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) access(d, 1, OP_W, 32'(i * 4), $urandom, 0, 0);

    for (int d = 0; d < 2; d++) directed(d);

    reset_mid_access();

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 250; i++) begin
        op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFFF000);
        access(d, 1'($urandom_range(0, 1)), op, a, $urandom, 0, 0);
      end
    end

    repeat (10) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("loads_outstanding", d, 32'(rd_cyc[d].size()), 32'd0);
      chk("misalign_outstanding", d, 32'(mis_cyc[d].size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors + 0);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
